// File: rtl/jk_bank_arb.sv
// jk_bank_arb: round-robin arbiter that serialises per-requester JK commands onto an NBITS-wide bank.
// Define JK_BANK_TGL_CNT_EN to add the saturating 8-bit toggle counter output tgl_cnt.
module jk_bank_arb #(
    parameter int NREQ  = 4,
    parameter int NBITS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] cmd,
    input  logic [3*NREQ-1:0] idx,
    output logic [NREQ-1:0]   gnt,
    output logic [NBITS-1:0]  q,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef JK_BANK_TGL_CNT_EN
    ,
    output logic [7:0]        tgl_cnt
`endif
);
    localparam int LW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        APPLY = 2'b10,
        BAD   = 2'b11
    } state_t;

    state_t        state, state_nxt;
    logic [LW-1:0] last_w, win;
    logic          win_vld;
    logic [1:0]    win_cmd, lat_cmd;
    logic [2:0]    win_idx, lat_idx;
    logic          idx_ok;

    function automatic logic jk_next(input logic cur, input logic [1:0] c);
        case (c)
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            2'b11:   return ~cur;
            default: return cur;
        endcase
    endfunction

    // Scan offsets from farthest to nearest so the nearest pending requester after last_w wins.
    always_comb begin
        int c;
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        c       = 0;
        win     = last_w;
        win_vld = 1'b0;
        win_cmd = '0;
        win_idx = '0;
        for (int i = NREQ; i >= 1; i--) begin
            c = (int'(last_w) + i) % NREQ;
            if (req[c]) begin
                win     = LW'(c);
                win_vld = 1'b1;
                win_cmd = cmd[2*c +: 2];
                win_idx = idx[3*c +: 3];
            end
        end
    end

    always_comb begin
        idx_ok = 1'b0;
        for (int b = 0; b < NBITS; b++) begin
            if (lat_idx == 3'(b)) idx_ok = 1'b1;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = win_vld ? GRANT : IDLE;
            GRANT:   state_nxt = APPLY;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt     <= '0;
            q       <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            last_w  <= LW'(NREQ - 1);
            lat_cmd <= '0;
            lat_idx <= '0;
        end else begin
            gnt  <= '0;
            done <= 1'b0;
            err  <= 1'b0;
            if (state == IDLE && win_vld) begin
                gnt     <= NREQ'(1) << win;
                last_w  <= win;
                lat_cmd <= win_cmd;
                lat_idx <= win_idx;
            end
            // The edge leaving GRANT commits the latched command; out-of-range targets only flag err.
            if (state == GRANT) begin
                done <= 1'b1;
                err  <= ~idx_ok;
                for (int b = 0; b < NBITS; b++) begin
                    if (lat_idx == 3'(b)) q[b] <= jk_next(q[b], lat_cmd);
                end
            end
        end
    end

`ifdef JK_BANK_TGL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgl_cnt <= '0;
        end else if (state == GRANT && idx_ok && lat_cmd == 2'b11 && tgl_cnt != 8'hFF) begin
            tgl_cnt <= tgl_cnt + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_jk_bank_arb.sv
// Scoreboard bench for jk_bank_arb: two instances (NBITS=8 and NBITS=6) share stimulus; a
// monitor pops expected grants and completions computed by a queue-based reference model.
module tb_jk_bank_arb;
    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [2*NREQ-1:0] cmd;
    logic [3*NREQ-1:0] idx;
    logic [NREQ-1:0]   gnt8, gnt6;
    logic [7:0]        q8;
    logic [5:0]        q6;
    logic              busy8, busy6, done8, done6, err8, err6;
`ifdef JK_BANK_TGL_CNT_EN
    logic [7:0]        tc8, tc6;
`endif

    jk_bank_arb #(.NREQ(NREQ), .NBITS(8)) dut8 (
        .clk(clk), .rst(rst), .req(req), .cmd(cmd), .idx(idx),
        .gnt(gnt8), .q(q8), .busy(busy8), .done(done8), .err(err8)
`ifdef JK_BANK_TGL_CNT_EN
        , .tgl_cnt(tc8)
`endif
    );

    jk_bank_arb #(.NREQ(NREQ), .NBITS(6)) dut6 (
        .clk(clk), .rst(rst), .req(req), .cmd(cmd), .idx(idx),
        .gnt(gnt6), .q(q6), .busy(busy6), .done(done6), .err(err6)
`ifdef JK_BANK_TGL_CNT_EN
        , .tgl_cnt(tc6)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NREQ-1:0] g;
        int              at;
    } gexp_t;

    typedef struct {
        logic [7:0] q8;
        logic [5:0] q6;
        bit         e8;
        bit         e6;
        int         at;
    } dexp_t;

    gexp_t gq[$];
    dexp_t dq[$];

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    int         last_w = NREQ - 1;
    logic [7:0] mq8    = '0;
    logic [7:0] mq6    = '0;
    int         mtgl8  = 0;
    int         mtgl6  = 0;

    // Requester-side state
    bit         pend[NREQ];
    logic [1:0] pc[NREQ];
    logic [2:0] pi[NREQ];
    bit         rand_en = 1'b0;

    task automatic check(input string name, input bit ok, input string detail);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s (t=%0t)", name, detail, $time);
    endtask

    function automatic logic [7:0] jk_model(input logic [7:0] v, input int pos, input logic [1:0] c);
        logic [7:0] m;
        m = 8'd1 << pos;
        case (c)
            2'b01:   return v & ~m;
            2'b10:   return v | m;
            2'b11:   return v ^ m;
            default: return v;
        endcase
    endfunction

    task automatic drive_bus();
        for (int r = 0; r < NREQ; r++) begin
            req[r]         = pend[r];
            cmd[2*r +: 2]  = pc[r];
            idx[3*r +: 3]  = pi[r];
        end
    endtask

    task automatic set_pend(input int r, input logic [1:0] c, input logic [2:0] i);
        pend[r] = 1'b1;
        pc[r]   = c;
        pi[r]   = i;
        drive_bus();
    endtask

    task automatic raise_rand(input int skip);
        if (!rand_en) return;
        for (int r = 0; r < NREQ; r++) begin
            if (r != skip && !pend[r] && $urandom_range(0, 2) == 0) begin
                pend[r] = 1'b1;
                pc[r]   = 2'($urandom_range(0, 3));
                pi[r]   = 3'($urandom_range(0, 7));
            end
        end
        drive_bus();
    endtask

    task automatic model_reset();
        last_w = NREQ - 1;
        mq8    = '0;
        mq6    = '0;
        mtgl8  = 0;
        mtgl6  = 0;
    endtask

    task automatic do_reset();
        for (int r = 0; r < NREQ; r++) pend[r] = 1'b0;
        drive_bus();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    // Called at a negedge while the DUT sits in IDLE; leaves at the negedge of the next IDLE cycle.
    task automatic step_txn(input bit abort);
        int    w;
        gexp_t ge;
        dexp_t de;
        w = -1;
        raise_rand(-1);
        for (int i = 1; i <= NREQ; i++) begin
            int c;
            c = (last_w + i) % NREQ;
            if (w < 0 && pend[c]) w = c;
        end
        if (w < 0) begin
            @(negedge clk);
            return;
        end
        ge.g  = NREQ'(1) << w;
        ge.at = cyc + 1;
        gq.push_back(ge);
        last_w = w;
        if (!abort) begin
            mq8 = jk_model(mq8, int'(pi[w]), pc[w]);
            if (pi[w] < 3'd6) mq6 = jk_model(mq6, int'(pi[w]), pc[w]);
            if (pc[w] == 2'b11) begin
                if (mtgl8 < 255) mtgl8++;
                if (pi[w] < 3'd6 && mtgl6 < 255) mtgl6++;
            end
            de.q8 = mq8;
            de.q6 = mq6[5:0];
            de.e8 = 1'b0;
            de.e6 = (pi[w] >= 3'd6);
            de.at = cyc + 2;
            dq.push_back(de);
        end

        @(negedge clk);  // GRANT cycle
        check("busy_grant", busy8 && busy6, $sformatf("busy8=%b busy6=%b want 1", busy8, busy6));
        pend[w] = 1'b0;
        pc[w]   = 2'($urandom_range(0, 3));
        pi[w]   = 3'($urandom_range(0, 7));
        drive_bus();
        if (abort) begin
            #2 rst = 1'b1;
            #1 check("abort_clear", gnt8 == '0 && q8 == '0 && q6 == '0 && !busy8 && !done8,
                     $sformatf("gnt=%b q8=%h q6=%h busy=%b done=%b want all 0", gnt8, q8, q6, busy8, done8));
            @(negedge clk);
            rst = 1'b0;
            model_reset();
            return;
        end

        @(negedge clk);  // APPLY cycle
        check("busy_apply", busy8 && busy6, $sformatf("busy8=%b busy6=%b want 1", busy8, busy6));
        raise_rand(-1);
        @(negedge clk);  // back in IDLE
        check("busy_idle", !busy8 && !busy6, $sformatf("busy8=%b busy6=%b want 0", busy8, busy6));
    endtask

    // Monitor: every grant and every completion the DUTs present is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (gnt8 != '0 || gnt6 != '0) begin
                if (gq.size() == 0) begin
                    check("gnt_unexpected", 1'b0, $sformatf("gnt8=%b gnt6=%b at cycle %0d, none expected", gnt8, gnt6, cyc));
                end else begin
                    gexp_t ge;
                    ge = gq.pop_front();
                    check("gnt", gnt8 == ge.g && gnt6 == ge.g && cyc == ge.at,
                          $sformatf("gnt8=%b gnt6=%b cycle %0d, want %b at cycle %0d", gnt8, gnt6, cyc, ge.g, ge.at));
                end
            end
            if (done8 || done6 || err8 || err6) begin
                if (dq.size() == 0) begin
                    check("done_unexpected", 1'b0, $sformatf("done8=%b done6=%b err8=%b err6=%b at cycle %0d, none expected",
                          done8, done6, err8, err6, cyc));
                end else begin
                    dexp_t de;
                    de = dq.pop_front();
                    check("done", done8 && done6 && q8 == de.q8 && q6 == de.q6 && err8 == de.e8 && err6 == de.e6 && cyc == de.at,
                          $sformatf("done=%b%b q8=%h q6=%h err=%b%b cycle %0d, want done=11 q8=%h q6=%h err=%b%b cycle %0d",
                          done8, done6, q8, q6, err8, err6, cyc, de.q8, de.q6, de.e8, de.e6, de.at));
                end
            end
        end
    end

    initial begin
        rst = 1'b0;
        for (int r = 0; r < NREQ; r++) begin
            pend[r] = 1'b0;
            pc[r]   = '0;
            pi[r]   = '0;
        end
        drive_bus();
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_gnt",  gnt8 == '0 && gnt6 == '0, $sformatf("gnt8=%b gnt6=%b want 0", gnt8, gnt6));
        check("rst_q",    q8 == '0 && q6 == '0, $sformatf("q8=%h q6=%h want 0", q8, q6));
        check("rst_flags", !busy8 && !done8 && !err8 && !busy6 && !done6 && !err6,
              $sformatf("busy=%b done=%b err=%b want 0", busy8, done8, err8));
        rst = 1'b0;
        @(negedge clk);

        // Single set on requester 0
        set_pend(0, 2'b10, 3'd3);
        step_txn(1'b0);
        check("q_set3", q8 == 8'h08, $sformatf("q8=%h want 08", q8));

        // All four requesting toggles: served 0,1,2,3 three cycles apart
        do_reset();
        for (int r = 0; r < NREQ; r++) set_pend(r, 2'b11, 3'(r));
        repeat (4) step_txn(1'b0);
        check("q_tgl4", q8 == 8'h0F, $sformatf("q8=%h want 0F", q8));

        // Fill, clear bit 7, then a hold command
        for (int i = 0; i < 8; i++) begin
            set_pend(1, 2'b10, 3'(i));
            step_txn(1'b0);
        end
        check("q_full", q8 == 8'hFF, $sformatf("q8=%h want FF", q8));
        set_pend(1, 2'b01, 3'd7);
        step_txn(1'b0);
        check("q_clr7", q8 == 8'h7F, $sformatf("q8=%h want 7F", q8));
        set_pend(1, 2'b00, 3'd7);
        step_txn(1'b0);
        check("q_hold", q8 == 8'h7F, $sformatf("q8=%h want 7F", q8));

        // Out-of-range index on the 6-bit bank
        set_pend(2, 2'b10, 3'd6);
        step_txn(1'b0);

        // Reset during GRANT aborts; the next winner is requester 0
        do_reset();
        set_pend(1, 2'b10, 3'd5);
        set_pend(2, 2'b10, 3'd4);
        step_txn(1'b1);
        set_pend(0, 2'b10, 3'd0);
        step_txn(1'b0);
        check("q_after_abort", q8 == 8'h01, $sformatf("q8=%h want 01", q8));
        step_txn(1'b0);

        // Randomized traffic, then drain
        rand_en = 1'b1;
        repeat (250) step_txn(1'b0);
        rand_en = 1'b0;
        for (int k = 0; k < 3 * NREQ; k++) step_txn(1'b0);
`ifdef JK_BANK_TGL_CNT_EN
        check("tgl_rand", int'(tc8) == mtgl8 && int'(tc6) == mtgl6,
              $sformatf("tgl_cnt8=%0d tgl_cnt6=%0d want %0d %0d", tc8, tc6, mtgl8, mtgl6));
        do_reset();
        repeat (260) begin
            set_pend(0, 2'b11, 3'd0);
            step_txn(1'b0);
        end
        check("tgl_sat", tc8 == 8'd255 && tc6 == 8'd255 && q8[0] == 1'b0,
              $sformatf("tgl_cnt8=%0d tgl_cnt6=%0d q8[0]=%b want 255 255 0", tc8, tc6, q8[0]));
`endif

        repeat (3) @(negedge clk);
        check("gnt_drained", gq.size() == 0, $sformatf("%0d grants never seen, want 0", gq.size()));
        check("done_drained", dq.size() == 0, $sformatf("%0d completions never seen, want 0", dq.size()));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/jk_bank_arb.md
JK_BANK_ARB -- requirements
Module: jk_bank_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning number of requesters (2..8).
REQ-002 SHALL have parameter NBITS, default 8, meaning number of JK storage bits in the bank (1..8).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  NREQ  per-requester request, level.
REQ-006 SHALL have port cmd  input  2*NREQ  packed per-requester JK command, requester r in bits [2r+1:2r]; bit1=J, bit0=K.
REQ-007 SHALL have port idx  input  3*NREQ  packed per-requester target bit index, requester r in bits [3r+2:3r].
REQ-008 SHALL have port gnt  output  NREQ  one-hot grant, registered.
REQ-009 SHALL have port q  output  NBITS  JK bank state, registered.
REQ-010 SHALL have port busy  output  1  high whenever FSM not in IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse: granted command completed.
REQ-012 SHALL have port err  output  1  one-cycle pulse, coincident with done: granted idx >= NBITS.

Function
REQ-013 SHALL implement FSM IDLE(2'b00) -> GRANT(2'b01) -> APPLY(2'b10) -> IDLE; encoding 2'b11 SHALL return to IDLE on the next edge.
REQ-014 In IDLE, if any req bit high, SHALL select a winner by round-robin, register gnt one-hot for the winner, latch its cmd and idx, and enter GRANT; otherwise remain in IDLE with gnt=0.
REQ-015 Round-robin search SHALL start at (last_winner+1) mod NREQ and wrap; last_winner SHALL update only on a grant.
REQ-016 gnt SHALL be high for exactly the single GRANT cycle; 0 in IDLE and APPLY.
REQ-017 On the edge ending GRANT, with latched idx < NBITS, q[idx] SHALL update per JK rule: 00 hold, 01 clear, 10 set, 11 toggle; all other q bits unchanged.
REQ-018 With latched idx >= NBITS, q SHALL remain unchanged and err SHALL pulse in APPLY.
REQ-019 done SHALL pulse high for the APPLY cycle of every grant, including hold (00) and error commands.
REQ-020 Requesters SHALL keep req/cmd/idx stable until gnt and deassert req by the APPLY cycle; req still high in the next IDLE SHALL be treated as a new request.
REQ-021 Latency: req sampled in IDLE cycle N -> gnt in N+1 -> q updated and done in N+2; maximum throughput one command per 3 cycles.
REQ-022 cmd/idx/req changes during GRANT or APPLY SHALL NOT affect the in-flight command.
REQ-023 Only one bank bit SHALL change per command; simultaneous requests SHALL be serialized, never merged.

Reset
REQ-024 rst high SHALL asynchronously force state=IDLE, q=0, gnt=0, done=0, err=0, busy=0, last_winner=NREQ-1, so requester 0 wins first.
REQ-025 rst asserted in GRANT or APPLY SHALL abort the command with no q update; no done pulse SHALL follow the deassertion of rst.

Configuration
REQ-026 Macro JK_BANK_TGL_CNT_EN defined: SHALL add output tgl_cnt (8 bits), incremented on each applied toggle (cmd 11, idx valid) and saturating at 255, reset to 0; toggles SHALL count even when q is already at the same value because another bit was written.
REQ-027 Macro JK_BANK_TGL_CNT_EN undefined: port tgl_cnt and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-028 After reset, req=4'b0001, cmd0=10, idx0=3 -> gnt=0001 next cycle, q=8'h08 and done=1 one cycle later, busy high for 2 cycles.
REQ-029 req=4'b1111 held until each gnt, all cmd=11, idx=r -> grant order 0,1,2,3; final q=8'h0F; 4 done pulses spaced 3 cycles apart.
REQ-030 q=8'hFF, req1 cmd=01 idx=7 -> q=8'h7F; repeat with cmd=00 -> q unchanged, done still pulses.
REQ-031 NBITS=6, req2 cmd=10 idx=6 -> q unchanged, err=1 and done=1 in the same cycle.
REQ-032 rst pulsed during GRANT of a set command -> q=0, gnt=0, no done afterward; the next request goes to requester 0.
REQ-033 With JK_BANK_TGL_CNT_EN, 260 toggle commands on idx 0 -> tgl_cnt=255, q[0]=0.
